// File: rtl/pic_alu_seq_pkg.sv
// Shared constants for the registered PIC ALU: function codes, STATUS bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_alu_seq_pkg;

  localparam int ALU_FUNC_WIDTH = 5;

  // ALU function codes driven by the decode stage
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IDLE   = 5'd0;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ADDWF  = 5'd1;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SUBWF  = 5'd2;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDWF  = 5'd3;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_COMF   = 5'd4;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_DECF   = 5'd5;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_INCF   = 5'd6;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORWF  = 5'd7;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MOVF   = 5'd8;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RLF    = 5'd9;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RRF    = 5'd10;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SWAPF  = 5'd11;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORWF  = 5'd12;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BCF    = 5'd13;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BSF    = 5'd14;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDLW  = 5'd15;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORLW  = 5'd16;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORLW  = 5'd17;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_DECFSZ = 5'd18;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_INCFSZ = 5'd19;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BTFSC  = 5'd20;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BTFSS  = 5'd21;
  localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MUL    = 5'd22;

  // Bit positions inside the {Z,DC,C} flag register
  localparam int ALU_STATUS_Z  = 2;
  localparam int ALU_STATUS_DC = 1;
  localparam int ALU_STATUS_C  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pic_alu_seq_if.sv
// Decode-stage <-> ALU bundle: start/ready/done handshake, operands and registered results.
// Latency: n/a (wires only).
// Backpressure: master may only launch when ready=1; starts while busy are dropped.
interface pic_alu_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
);
  import pic_alu_seq_pkg::*;

  logic                      start;
  logic [ALU_FUNC_WIDTH-1:0] funcIn;
  logic [DATA_WIDTH-1:0]     wIn;
  logic [DATA_WIDTH-1:0]     fIn;
  logic [DATA_WIDTH-1:0]     lIn;
  logic [SEL_WIDTH-1:0]      bitSel;
  logic                      statusLoad;
  logic [2:0]                statusDin;
  logic                      ready;
  logic                      done;
  logic [DATA_WIDTH-1:0]     aluResultOut;
  logic [DATA_WIDTH-1:0]     aluResultHi;
  logic                      aluSkip;
  logic [2:0]                aluStatusOut;

  modport master (
    output start, funcIn, wIn, fIn, lIn, bitSel, statusLoad, statusDin,
    input  ready, done, aluResultOut, aluResultHi, aluSkip, aluStatusOut
  );

  modport slave (
    input  start, funcIn, wIn, fIn, lIn, bitSel, statusLoad, statusDin,
    output ready, done, aluResultOut, aluResultHi, aluSkip, aluStatusOut
  );

endinterface

// File: rtl/pic_alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Latency: done strobes combinationally in the DATA_WIDTH-th cycle after start; product valid with it.
// Backpressure: none; caller must not restart while busy (a start simply reloads the operands).
module alu_mul_iter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W:0]    sum;

  // Product register holds {partial_hi, remaining multiplier bits}; each step adds and shifts right.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    done    = 1'b0;
    sum     = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = CW'(DATA_WIDTH);
      mcand_d = a;
      prod_d  = {{W{1'b0}}, b};
    end else if (busy_q) begin
      prod_d = {sum, prod_q[W-1:1]};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
    product = prod_d;
  end

  // Iteration state; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/pic_alu_seq.sv
// Registered PIC ALU with STATUS {Z,DC,C} ownership, skip-test ops and iterative MUL.
// Latency: single-cycle ops done 1 cycle after acceptance; MUL done DATA_WIDTH+1 cycles after.
// Backpressure: ready low while busy (ready again in MUL's done cycle); starts while busy are ignored.
module pic_alu_seq
  import pic_alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic          clk,
  input  logic          rst,
  pic_alu_seq_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  state_e         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   hi_q, hi_d;
  logic           skip_q, skip_d;
  logic           done_q, done_d;
  logic [2:0]     flags_q, flags_d;

  logic           ready, accept, is_mul;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W:0]     add_full;
  logic [4:0]     add_nib;
  logic [W-1:0]   op_res;
  logic [2:0]     op_flags;
  logic           op_skip, z_upd;

  // MUL's DONE cycle also accepts, so a new op can launch while done is high.
  assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept   = bus.start && ready;
  assign is_mul   = (bus.funcIn == ALU_MUL);
  assign add_full = {1'b0, bus.fIn} + {1'b0, bus.wIn};
  assign add_nib  = {1'b0, bus.fIn[3:0]} + {1'b0, bus.wIn[3:0]};

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (bus.fIn),
    .b       (bus.wIn),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle op datapath: result, updated flags and skip from the live operands.
  always_comb begin
    op_res   = '0;
    op_flags = flags_q;
    op_skip  = 1'b0;
    z_upd    = 1'b0;
    case (bus.funcIn)
      ALU_ADDWF: begin
        op_res = add_full[W-1:0];
        op_flags[ALU_STATUS_C]  = add_full[W];
        op_flags[ALU_STATUS_DC] = add_nib[4];
        z_upd = 1'b1;
      end
      ALU_SUBWF: begin
        op_res = bus.fIn - bus.wIn;
        op_flags[ALU_STATUS_C]  = (bus.fIn >= bus.wIn);
        op_flags[ALU_STATUS_DC] = (bus.fIn[3:0] >= bus.wIn[3:0]);
        z_upd = 1'b1;
      end
      ALU_ANDWF: begin op_res = bus.fIn & bus.wIn; z_upd = 1'b1; end
      ALU_IORWF: begin op_res = bus.fIn | bus.wIn; z_upd = 1'b1; end
      ALU_XORWF: begin op_res = bus.fIn ^ bus.wIn; z_upd = 1'b1; end
      ALU_ANDLW: begin op_res = bus.lIn & bus.wIn; z_upd = 1'b1; end
      ALU_IORLW: begin op_res = bus.lIn | bus.wIn; z_upd = 1'b1; end
      ALU_XORLW: begin op_res = bus.lIn ^ bus.wIn; z_upd = 1'b1; end
      ALU_COMF:  begin op_res = ~bus.fIn;          z_upd = 1'b1; end
      ALU_INCF:  begin op_res = bus.fIn + W'(1);   z_upd = 1'b1; end
      ALU_DECF:  begin op_res = bus.fIn - W'(1);   z_upd = 1'b1; end
      ALU_MOVF:  begin op_res = bus.fIn;           z_upd = 1'b1; end
      ALU_INCFSZ: begin op_res = bus.fIn + W'(1); op_skip = (op_res == '0); end
      ALU_DECFSZ: begin op_res = bus.fIn - W'(1); op_skip = (op_res == '0); end
      ALU_SWAPF: begin
        op_res      = bus.fIn;
        op_res[7:4] = bus.fIn[3:0];
        op_res[3:0] = bus.fIn[7:4];
      end
      ALU_BCF: begin op_res = bus.fIn; op_res[bus.bitSel] = 1'b0; end
      ALU_BSF: begin op_res = bus.fIn; op_res[bus.bitSel] = 1'b1; end
      ALU_BTFSC: begin op_res = bus.fIn; op_skip = ~bus.fIn[bus.bitSel]; end
      ALU_BTFSS: begin op_res = bus.fIn; op_skip = bus.fIn[bus.bitSel]; end
      ALU_RLF: begin
        op_res = {bus.fIn[W-2:0], flags_q[ALU_STATUS_C]};
        op_flags[ALU_STATUS_C] = bus.fIn[W-1];
      end
      ALU_RRF: begin
        op_res = {flags_q[ALU_STATUS_C], bus.fIn[W-1:1]};
        op_flags[ALU_STATUS_C] = bus.fIn[0];
      end
      default: op_res = '0;
    endcase
    if (z_upd) op_flags[ALU_STATUS_Z] = (op_res == '0);
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = is_mul ? ST_MUL : ST_EXEC;
        else        state_d = ST_IDLE;
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_MUL:  if (mul_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/flag register updates; a direct STATUS write overrides any ALU flag update.
  always_comb begin
    result_d = result_q;
    hi_d     = hi_q;
    skip_d   = skip_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    if (accept && !is_mul) begin
      result_d = op_res;
      hi_d     = '0;
      skip_d   = op_skip;
      flags_d  = op_flags;
      done_d   = 1'b1;
    end else if (mul_done) begin
      result_d = mul_prod[W-1:0];
      hi_d     = mul_prod[2*W-1:W];
      skip_d   = 1'b0;
      flags_d[ALU_STATUS_Z] = (mul_prod == '0);
      flags_d[ALU_STATUS_C] = (mul_prod[2*W-1:W] != '0);
      done_d   = 1'b1;
    end
    if (bus.statusLoad) flags_d = bus.statusDin;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      skip_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      skip_q   <= skip_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.ready        = ready;
  assign bus.done         = done_q;
  assign bus.aluResultOut = result_q;
  assign bus.aluResultHi  = hi_q;
  assign bus.aluSkip      = skip_q;
  assign bus.aluStatusOut = flags_q;

endmodule

// File: tb/tb_pic_alu_seq.sv
// Bench for pic_alu_seq: vector table, MUL/reset/collision sequences, random ops vs reference model.
// Latency: checks done timing of every op.
// Backpressure: waits for ready before each launch.
module tb_pic_alu_seq;
  import pic_alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pic_alu_seq_if #(.DATA_WIDTH(8), .SEL_WIDTH(3)) bus ();
  pic_alu_seq #(.DATA_WIDTH(8), .SEL_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] fn;
    logic [7:0] f, w, l;
    logic [2:0] sel, fin;
    logic [7:0] res, hi;
    logic [2:0] fo;
    logic       sk;
  } vec_t;
  vec_t tv[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the instruction definitions.
  function automatic void model(input logic [4:0] fn, input int f, input int w, input int l,
                                input int sel, input logic [2:0] fin, output int res,
                                output int hi, output logic [2:0] fo, output logic sk);
    logic z, dc, c, zu;
    int p;
    {z, dc, c} = fin;
    res = 0; hi = 0; sk = 1'b0; zu = 1'b0;
    case (fn)
      ALU_ADDWF: begin res = (f + w) % 256; c = (f + w) > 255; dc = (f % 16 + w % 16) > 15; zu = 1; end
      ALU_SUBWF: begin res = (f - w + 256) % 256; c = f >= w; dc = (f % 16) >= (w % 16); zu = 1; end
      ALU_ANDWF: begin res = f & w; zu = 1; end
      ALU_IORWF: begin res = f | w; zu = 1; end
      ALU_XORWF: begin res = f ^ w; zu = 1; end
      ALU_ANDLW: begin res = l & w; zu = 1; end
      ALU_IORLW: begin res = l | w; zu = 1; end
      ALU_XORLW: begin res = l ^ w; zu = 1; end
      ALU_COMF:  begin res = 255 - f; zu = 1; end
      ALU_INCF:  begin res = (f + 1) % 256; zu = 1; end
      ALU_DECF:  begin res = (f + 255) % 256; zu = 1; end
      ALU_MOVF:  begin res = f; zu = 1; end
      ALU_INCFSZ: begin res = (f + 1) % 256; sk = (res == 0); end
      ALU_DECFSZ: begin res = (f + 255) % 256; sk = (res == 0); end
      ALU_SWAPF: res = (f % 16) * 16 + f / 16;
      ALU_BCF:   res = f & (255 - (1 << sel));
      ALU_BSF:   res = f | (1 << sel);
      ALU_BTFSC: begin res = f; sk = ((f >> sel) & 1) == 0; end
      ALU_BTFSS: begin res = f; sk = ((f >> sel) & 1) == 1; end
      ALU_RLF:   begin res = (f * 2 + int'(c)) % 256; c = f >= 128; end
      ALU_RRF:   begin res = f / 2 + (c ? 128 : 0); c = (f % 2) == 1; end
      ALU_MUL:   begin p = f * w; res = p % 256; hi = p / 256; z = (p == 0); c = (hi != 0); end
      default:   res = 0;
    endcase
    if (zu) z = (res == 0);
    fo = {z, dc, c};
  endfunction

  task automatic set_flags(input logic [2:0] v);
    @(negedge clk);
    bus.statusLoad = 1'b1;
    bus.statusDin  = v;
    @(negedge clk);
    bus.statusLoad = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
  endtask

  // Launch one op, scramble operands after acceptance, return cycles until done.
  task automatic issue(input logic [4:0] fn, input logic [7:0] f, input logic [7:0] w,
                       input logic [7:0] l, input logic [2:0] sel,
                       output int lat, output logic rdy1);
    wait_ready();
    bus.start = 1'b1; bus.funcIn = fn; bus.fIn = f; bus.wIn = w; bus.lIn = l; bus.bitSel = sel;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.fIn = 8'($urandom); bus.wIn = 8'($urandom); bus.lIn = 8'($urandom);
    bus.bitSel = 3'($urandom); bus.funcIn = 5'($urandom);
    rdy1 = bus.ready;
    lat = 1;
    while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!bus.done) chk("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    int lat, mres, mhi, seen;
    logic rdy1, msk;
    logic [2:0] mf, mflags;
    logic [4:0] fn;
    logic [7:0] f, w, l;
    logic [2:0] sel;

    tv[0]  = '{ALU_ADDWF,  8'h0F, 8'h01, 8'h00, 3'd0, 3'b000, 8'h10, 8'h00, 3'b010, 1'b0};
    tv[1]  = '{ALU_ADDWF,  8'hFF, 8'h01, 8'h00, 3'd0, 3'b000, 8'h00, 8'h00, 3'b111, 1'b0};
    tv[2]  = '{ALU_SUBWF,  8'h10, 8'h01, 8'h00, 3'd0, 3'b000, 8'h0F, 8'h00, 3'b001, 1'b0};
    tv[3]  = '{ALU_SUBWF,  8'h01, 8'h02, 8'h00, 3'd0, 3'b000, 8'hFF, 8'h00, 3'b000, 1'b0};
    tv[4]  = '{ALU_RLF,    8'h80, 8'h00, 8'h00, 3'd0, 3'b001, 8'h01, 8'h00, 3'b001, 1'b0};
    tv[5]  = '{ALU_RRF,    8'h00, 8'h00, 8'h00, 3'd0, 3'b001, 8'h80, 8'h00, 3'b000, 1'b0};
    tv[6]  = '{ALU_DECFSZ, 8'h01, 8'h00, 8'h00, 3'd0, 3'b101, 8'h00, 8'h00, 3'b101, 1'b1};
    tv[7]  = '{ALU_BTFSS,  8'h04, 8'h00, 8'h00, 3'd2, 3'b000, 8'h04, 8'h00, 3'b000, 1'b1};
    tv[8]  = '{ALU_BTFSC,  8'h04, 8'h00, 8'h00, 3'd2, 3'b000, 8'h04, 8'h00, 3'b000, 1'b0};
    tv[9]  = '{ALU_ANDLW,  8'h00, 8'hF0, 8'h0F, 3'd0, 3'b000, 8'h00, 8'h00, 3'b100, 1'b0};
    tv[10] = '{ALU_SWAPF,  8'hA5, 8'h00, 8'h00, 3'd0, 3'b011, 8'h5A, 8'h00, 3'b011, 1'b0};
    tv[11] = '{ALU_BSF,    8'h00, 8'h00, 8'h00, 3'd7, 3'b000, 8'h80, 8'h00, 3'b000, 1'b0};
    tv[12] = '{ALU_COMF,   8'hFF, 8'h00, 8'h00, 3'd0, 3'b011, 8'h00, 8'h00, 3'b111, 1'b0};
    tv[13] = '{ALU_INCFSZ, 8'hFF, 8'h00, 8'h00, 3'd0, 3'b000, 8'h00, 8'h00, 3'b000, 1'b1};
    tv[14] = '{5'd31,      8'h12, 8'h34, 8'h56, 3'd0, 3'b110, 8'h00, 8'h00, 3'b110, 1'b0};
    tv[15] = '{ALU_MUL,    8'hFF, 8'hFF, 8'h00, 3'd0, 3'b000, 8'h01, 8'hFE, 3'b001, 1'b0};
    tv[16] = '{ALU_BCF,    8'hFF, 8'h00, 8'h00, 3'd3, 3'b010, 8'hF7, 8'h00, 3'b010, 1'b0};

    bus.start = 1'b0; bus.funcIn = '0; bus.wIn = '0; bus.fIn = '0; bus.lIn = '0;
    bus.bitSel = '0; bus.statusLoad = 1'b0; bus.statusDin = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_result", {24'd0, bus.aluResultOut}, 32'd0);
    chk("rst_hi",     {24'd0, bus.aluResultHi}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_skip",   {31'd0, bus.aluSkip}, 32'd0);
    chk("rst_flags",  {29'd0, bus.aluStatusOut}, 32'd0);
    chk("rst_ready",  {31'd0, bus.ready}, 32'd1);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      set_flags(tv[i].fin);
      issue(tv[i].fn, tv[i].f, tv[i].w, tv[i].l, tv[i].sel, lat, rdy1);
      chk($sformatf("tv%0d_result", i), {24'd0, bus.aluResultOut}, {24'd0, tv[i].res});
      chk($sformatf("tv%0d_hi", i),     {24'd0, bus.aluResultHi},  {24'd0, tv[i].hi});
      chk($sformatf("tv%0d_flags", i),  {29'd0, bus.aluStatusOut}, {29'd0, tv[i].fo});
      chk($sformatf("tv%0d_skip", i),   {31'd0, bus.aluSkip},      {31'd0, tv[i].sk});
      chk($sformatf("tv%0d_latency", i), lat, (tv[i].fn == ALU_MUL) ? 9 : 1);
      chk($sformatf("tv%0d_busy", i),   {31'd0, rdy1}, 32'd0);
    end

    // MUL with stray start pulses while busy
    set_flags(3'b000);
    wait_ready();
    bus.start = 1'b1; bus.funcIn = ALU_MUL; bus.fIn = 8'hFF; bus.wIn = 8'hFF;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (lat == 2 || lat == 4) begin
        bus.start = 1'b1; bus.funcIn = ALU_ADDWF; bus.fIn = 8'h01; bus.wIn = 8'h01;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("mulbusy_latency", lat, 9);
    chk("mulbusy_lo", {24'd0, bus.aluResultOut}, 32'h01);
    chk("mulbusy_hi", {24'd0, bus.aluResultHi}, 32'hFE);
    chk("mulbusy_flags", {29'd0, bus.aluStatusOut}, 32'b001);
    @(posedge clk); #1;
    chk("mulbusy_done_pulse", {31'd0, bus.done}, 32'd0);

    // Reset 4 cycles into a MUL
    set_flags(3'b101);
    wait_ready();
    bus.start = 1'b1; bus.funcIn = ALU_MUL; bus.fIn = 8'h03; bus.wIn = 8'h05;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_result", {24'd0, bus.aluResultOut}, 32'd0);
    chk("abort_hi",     {24'd0, bus.aluResultHi}, 32'd0);
    chk("abort_flags",  {29'd0, bus.aluStatusOut}, 32'd0);
    chk("abort_done",   {31'd0, bus.done}, 32'd0);
    chk("abort_ready",  {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (bus.done) seen++; end
    chk("abort_no_done", seen, 0);

    // statusLoad colliding with an ADDWF flag update
    wait_ready();
    bus.start = 1'b1; bus.funcIn = ALU_ADDWF; bus.fIn = 8'hFF; bus.wIn = 8'h01;
    bus.statusLoad = 1'b1; bus.statusDin = 3'b100;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.statusLoad = 1'b0;
    chk("collide_done",   {31'd0, bus.done}, 32'd1);
    chk("collide_result", {24'd0, bus.aluResultOut}, 32'd0);
    chk("collide_flags",  {29'd0, bus.aluStatusOut}, 32'b100);

    // Random ops against the reference model
    mf = 3'($urandom);
    set_flags(mf);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mf = 3'($urandom);
        set_flags(mf);
      end
      fn  = ($urandom_range(0, 23) == 23) ? 5'd31 : 5'($urandom_range(0, 22));
      f   = 8'($urandom); w = 8'($urandom); l = 8'($urandom); sel = 3'($urandom);
      if ($urandom_range(0, 7) == 0) f = 8'h00;
      model(fn, int'(f), int'(w), int'(l), int'(sel), mf, mres, mhi, mflags, msk);
      issue(fn, f, w, l, sel, lat, rdy1);
      chk($sformatf("rnd%0d_fn%0d_result", i, fn), {24'd0, bus.aluResultOut}, mres);
      chk($sformatf("rnd%0d_fn%0d_hi", i, fn),     {24'd0, bus.aluResultHi}, mhi);
      chk($sformatf("rnd%0d_fn%0d_flags", i, fn),  {29'd0, bus.aluStatusOut}, {29'd0, mflags});
      chk($sformatf("rnd%0d_fn%0d_skip", i, fn),   {31'd0, bus.aluSkip}, {31'd0, msk});
      chk($sformatf("rnd%0d_fn%0d_latency", i, fn), lat, (fn == ALU_MUL) ? 9 : 1);
      mf = mflags;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
